tcdm_copy_initiator: RTL and testbench

- TCDM master-side copy engine. Issues word reads from a source region and word writes to a destination region over one 32-bit TCDM initiator port.
- Typical connection: one input of the L2 tcdm_interconnect (fixed 1-cycle response latency, responses also returned for writes).
- Used for L2-to-L2 block moves without involving the AXI path.
- Programmed by a start pulse with source, destination and word count. Reports busy, done and a protocol error flag.

---
 rtl/tcdm_copy_initiator_if.sv | 16 +
 rtl/tcdm_copy_initiator.sv | 175 +++++++++++++++++
 tb/tb_tcdm_copy_initiator.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_copy_initiator_if.sv
// TCDM initiator-port bundle: one request channel plus its fixed-latency response channel.
interface tcdm_copy_initiator_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  gnt;
  logic                  r_valid;
  logic [31:0]           r_rdata;

  modport master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata);
  modport slave  (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata);
endinterface

// File: rtl/tcdm_copy_initiator.sv
// Word-by-word block copy over a single TCDM initiator port: reads fill a small
// FIFO, writes drain it, with read issue throttled by FIFO credits.
module tcdm_copy_initiator #(
  parameter int BUF_DEPTH  = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  tcdm_copy_initiator_if.master tcdm
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CTR_W = LEN_WIDTH + 1;
  localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_INC  = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_WAIT, S_DONE} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] src_ptr_reg, dst_ptr_reg;
  logic [CTR_W-1:0]      len_reg, reads_issued_reg, writes_granted_reg, writes_acked_reg;
  logic                  resp_vld_reg, resp_rd_reg;
  logic [31:0]           fifo_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg;
  logic                  req_reg, wen_reg;
  logic [ADDR_WIDTH-1:0] add_reg;
  logic [31:0]           wdata_reg;
  logic                  busy_reg, done_reg, err_reg;

  logic             granted, rd_granted, wr_granted;
  logic             rsp_rd, rsp_wr, rsp_spurious;
  logic             fifo_push, fifo_pop;
  logic             can_issue, issue_wr, issue_rd;
  logic             last_wr_grant, last_wr_ack;
  logic [CNT_W:0]   credit_sum;

  assign granted      = req_reg & tcdm.gnt;
  assign rd_granted   = granted & wen_reg;
  assign wr_granted   = granted & ~wen_reg;
  assign rsp_rd       = tcdm.r_valid & resp_vld_reg & resp_rd_reg;
  assign rsp_wr       = tcdm.r_valid & resp_vld_reg & ~resp_rd_reg;
  assign rsp_spurious = tcdm.r_valid & ~resp_vld_reg;
  assign fifo_push    = rsp_rd;

  // Credits cover buffered words, the word landing now and the read granted now.
  assign credit_sum = {1'b0, fifo_count_reg} + (CNT_W+1)'(fifo_push) + (CNT_W+1)'(rd_granted);
  assign can_issue  = (state_reg == S_COPY) && (!req_reg || tcdm.gnt);
  assign issue_wr   = can_issue && (fifo_count_reg != '0);
  assign issue_rd   = can_issue && !issue_wr && (reads_issued_reg < len_reg) && (credit_sum < DEPTH_C);
  assign fifo_pop   = issue_wr;

  assign last_wr_grant = wr_granted && ((writes_granted_reg + CTR_W'(1)) == len_reg);
  assign last_wr_ack   = rsp_wr && ((writes_acked_reg + CTR_W'(1)) == len_reg);

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_mem[fifo_wr_ptr_reg] <= tcdm.r_rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= S_IDLE;
      src_ptr_reg        <= '0;
      dst_ptr_reg        <= '0;
      len_reg            <= '0;
      reads_issued_reg   <= '0;
      writes_granted_reg <= '0;
      writes_acked_reg   <= '0;
      resp_vld_reg       <= 1'b0;
      resp_rd_reg        <= 1'b0;
      fifo_wr_ptr_reg    <= '0;
      fifo_rd_ptr_reg    <= '0;
      fifo_count_reg     <= '0;
      req_reg            <= 1'b0;
      wen_reg            <= 1'b1;
      add_reg            <= '0;
      wdata_reg          <= '0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      resp_vld_reg <= granted;
      resp_rd_reg  <= wen_reg;
      done_reg     <= 1'b0;

      if (fifo_push) fifo_wr_ptr_reg <= fifo_wr_ptr_reg + PTR_W'(1);
      if (fifo_pop)  fifo_rd_ptr_reg <= fifo_rd_ptr_reg + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase

      if (wr_granted) writes_granted_reg <= writes_granted_reg + CTR_W'(1);
      if (rsp_wr)     writes_acked_reg   <= writes_acked_reg + CTR_W'(1);

      // A request stays registered until granted; the next one is loaded in the grant cycle.
      if (issue_wr) begin
        req_reg     <= 1'b1;
        wen_reg     <= 1'b0;
        add_reg     <= dst_ptr_reg;
        wdata_reg   <= fifo_mem[fifo_rd_ptr_reg];
        dst_ptr_reg <= dst_ptr_reg + WORD_INC;
      end else if (issue_rd) begin
        req_reg          <= 1'b1;
        wen_reg          <= 1'b1;
        add_reg          <= src_ptr_reg;
        src_ptr_reg      <= src_ptr_reg + WORD_INC;
        reads_issued_reg <= reads_issued_reg + CTR_W'(1);
      end else if (granted) begin
        req_reg <= 1'b0;
        wen_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            src_ptr_reg        <= src_addr_i & ALIGN_MSK;
            dst_ptr_reg        <= dst_addr_i & ALIGN_MSK;
            len_reg            <= CTR_W'(len_i);
            reads_issued_reg   <= '0;
            writes_granted_reg <= '0;
            writes_acked_reg   <= '0;
            err_reg            <= 1'b0;
            if (len_i != '0) begin
              state_reg <= S_COPY;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= S_DONE;
            end
          end
        end
        S_COPY: begin
          if (rsp_spurious)  err_reg   <= 1'b1;
          if (last_wr_grant) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (rsp_spurious) err_reg <= 1'b1;
          if (last_wr_ack) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign tcdm.req   = req_reg;
  assign tcdm.add   = add_reg;
  assign tcdm.wen   = wen_reg;
  assign tcdm.wdata = wdata_reg;
  assign tcdm.be    = 4'hF;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;

  a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && !fifo_pop && (fifo_count_reg == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_tcdm_copy_initiator.sv
// Bench for tcdm_copy_initiator: memory-model responder plus read/write scoreboard.
module tb_tcdm_copy_initiator;
  localparam int BUF_DEPTH  = 4;
  localparam int LEN_WIDTH  = 16;
  localparam int ADDR_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  start_i = 1'b0;
  logic [ADDR_WIDTH-1:0] src_addr_i = '0;
  logic [ADDR_WIDTH-1:0] dst_addr_i = '0;
  logic [LEN_WIDTH-1:0]  len_i = '0;
  logic                  busy_o, done_o, err_o;

  tcdm_copy_initiator_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  tcdm_copy_initiator #(
    .BUF_DEPTH (BUF_DEPTH),
    .LEN_WIDTH (LEN_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .tcdm      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  wr_exp_t     exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mem_model [bit [31:0]];
  int          gnt_pct = 100;
  bit          inject_spur = 1'b0;
  int          busy_cnt = 0, done_cnt = 0, req_cnt = 0, wr_xfer_cnt = 0;
  int          rd_granted = 0, wr_presented = 0, max_occ = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: grants at gnt_pct, returns one response per transfer a cycle later.
  initial begin : responder
    bit          resp_pend;
    logic [31:0] resp_data;
    bit          prev_stall, prev_req, prev_xfer, xfer;
    logic        prev_wen;
    logic [31:0] prev_add, prev_wdata;
    wr_exp_t     e;
    logic [31:0] ra;
    int          occ;
    resp_pend = 0; resp_data = '0; prev_stall = 0; prev_req = 0; prev_xfer = 0;
    prev_wen = 1'b1; prev_add = '0; prev_wdata = '0;
    bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.r_valid = resp_pend || inject_spur;
      bus.r_rdata = resp_pend ? resp_data : 32'h0BAD_0BAD;
      inject_spur = 1'b0;
      bus.gnt = ($urandom_range(0, 99) < gnt_pct);
      @(negedge clk);
      if (!rst_ni) begin
        resp_pend = 0; prev_stall = 0; prev_req = 0; prev_xfer = 0;
        continue;
      end
      busy_cnt += int'(busy_o);
      done_cnt += int'(done_o);
      req_cnt  += int'(bus.req);
      if (prev_stall) begin
        check_value("hold_ctl", {bus.req, bus.wen, bus.add}, {1'b1, prev_wen, prev_add});
        check_value("hold_wdata", bus.wdata, prev_wdata);
      end
      if (bus.req && !bus.wen && (!prev_req || prev_xfer)) wr_presented++;
      xfer = bus.req && bus.gnt;
      resp_pend = xfer;
      if (xfer) begin
        if (bus.wen) begin
          rd_granted++;
          check_value("rd_expected", exp_rd_q.size() != 0, 1);
          if (exp_rd_q.size() != 0) begin
            ra = exp_rd_q.pop_front();
            check_value("rd_addr", bus.add, ra);
          end
          resp_data = mem_model.exists(bus.add) ? mem_model[bus.add] : 32'hDEAD_BEEF;
        end else begin
          wr_xfer_cnt++;
          check_value("wr_expected", exp_wr_q.size() != 0, 1);
          if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            check_value("wr_addr", bus.add, e.addr);
            check_value("wr_data", bus.wdata, e.data);
          end
          check_value("wr_be", bus.be, 4'hF);
          mem_model[bus.add] = bus.wdata;
        end
      end
      occ = rd_granted - wr_presented;
      if (occ > max_occ) max_occ = occ;
      prev_stall = bus.req && !bus.gnt;
      prev_req   = bus.req;
      prev_xfer  = xfer;
      prev_wen   = bus.wen;
      prev_add   = bus.add;
      prev_wdata = bus.wdata;
    end
  end

  task automatic preload(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) mem_model[base + 32'(4 * i)] = $urandom();
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input bit accept);
    logic [31:0] a;
    @(posedge clk); #1;
    if (accept) begin
      rd_granted = 0; wr_presented = 0; max_occ = 0;
      busy_cnt = 0; done_cnt = 0; req_cnt = 0; wr_xfer_cnt = 0;
      for (int i = 0; i < len; i++) begin
        a = (src & ~32'h3) + 32'(4 * i);
        exp_rd_q.push_back(a);
        exp_wr_q.push_back('{addr: (dst & ~32'h3) + 32'(4 * i),
                             data: mem_model.exists(a) ? mem_model[a] : 32'hDEAD_BEEF});
      end
    end
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LEN_WIDTH'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    $display("copy job: src=%08h dst=%08h len=%0d expect_accept=%0d gnt_pct=%0d", src, dst, len, accept, gnt_pct);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_value({tag, "_done"}, done_o, 1);
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_value({tag, "_done_once"}, done_cnt, 1);
    check_value({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
    check_value({tag, "_rd_q_empty"}, exp_rd_q.size(), 0);
    check_value({tag, "_busy_after"}, busy_o, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_req", bus.req, 0);
    check_value("rst_wen", bus.wen, 1);
    check_value("rst_add", bus.add, 0);
    check_value("rst_busy", busy_o, 0);
    check_value("rst_done", done_o, 0);
    check_value("rst_err", err_o, 0);
    @(negedge clk); rst_ni = 1'b1;

    // Basic copy
    for (int i = 0; i < 4; i++) mem_model[32'h1C00_0000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    gnt_pct = 100;
    start_copy(32'h1C00_0000, 32'h1C00_1000, 4, 1);
    wait_done("basic", 100);
    check_value("basic_busy_ge9", busy_cnt >= 9, 1);
    check_value("basic_err", err_o, 0);
    for (int i = 0; i < 4; i++)
      check_value("basic_dst", mem_model[32'h1C00_1000 + 32'(4 * i)], 32'hA0 + 32'(i));

    // Zero length
    start_copy(32'h1C00_0000, 32'h1C00_1100, 0, 1);
    @(negedge clk); #1;
    check_value("len0_done_c1", done_o, 0);
    @(negedge clk); #1;
    check_value("len0_done_c2", done_o, 1);
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_value("len0_req_cnt", req_cnt, 0);
    check_value("len0_busy_cnt", busy_cnt, 0);
    check_value("len0_done_cnt", done_cnt, 1);

    // Grant stalls
    preload(32'h1C00_2000, 64);
    gnt_pct = 30;
    start_copy(32'h1C00_2000, 32'h1C00_4000, 64, 1);
    wait_done("stall", 5000);
    check_value("stall_occ_le_depth", max_occ <= BUF_DEPTH, 1);
    check_value("stall_err", err_o, 0);

    // Source pointer wrap, unaligned low bits ignored
    preload(32'hFFFF_FFF8, 2);
    preload(32'h0000_0000, 2);
    gnt_pct = 100;
    start_copy(32'hFFFF_FFFA, 32'h1C00_5001, 4, 1);
    wait_done("wrap", 200);
    check_value("wrap_err", err_o, 0);

    // Spurious response while stalled in COPY, start while busy, sticky error
    preload(32'h1C00_6000, 8);
    gnt_pct = 0;
    start_copy(32'h1C00_6000, 32'h1C00_7000, 8, 1);
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_value("err_before_spur", err_o, 0);
    check_value("busy_stalled", busy_o, 1);
    @(negedge clk); inject_spur = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
    end
    check_value("err_after_spur", err_o, 1);
    start_copy(32'h1C00_8000, 32'h1C00_9000, 4, 0);
    gnt_pct = 100;
    wait_done("busy_start", 300);
    check_value("err_sticky", err_o, 1);
    start_copy(32'h1C00_6000, 32'h1C00_A000, 2, 1);
    check_value("err_cleared", err_o, 0);
    wait_done("after_err", 100);
    check_value("after_err_err", err_o, 0);

    // Reset in the middle of a copy
    preload(32'h1C00_B000, 32);
    start_copy(32'h1C00_B000, 32'h1C00_C000, 32, 1);
    for (int n = 0; n < 500 && wr_xfer_cnt < 10; n++) begin
      @(negedge clk); #1;
    end
    check_value("midrst_progress", wr_xfer_cnt >= 10, 1);
    rst_ni = 1'b0;
    #1;
    check_value("midrst_req", bus.req, 0);
    check_value("midrst_wen", bus.wen, 1);
    check_value("midrst_add", bus.add, 0);
    check_value("midrst_busy", busy_o, 0);
    check_value("midrst_done", done_o, 0);
    check_value("midrst_err", err_o, 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk); inject_spur = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
    end
    check_value("idle_spur_err", err_o, 0);
    preload(32'h1C00_D000, 8);
    start_copy(32'h1C00_D000, 32'h1C00_E000, 8, 1);
    wait_done("fresh", 200);
    check_value("fresh_err", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
